// File: rtl/mips_pkg.sv
// Shared MIPS constants and types for the register file and its neighbours.
package mips_pkg;
    localparam int MIPS_XLEN  = 32;
    localparam int MIPS_NREGS = 32;

    typedef logic [4:0] reg_addr_t;

    localparam reg_addr_t ZERO_IDX = 5'd0;
endpackage

// File: rtl/register_file_2r1w_if.sv
// Decode/write-back side bus of the register file: two read ports, one write port.
interface register_file_2r1w_if
    import mips_pkg::*;
#(
    parameter int WIDTH = MIPS_XLEN,
    parameter int DEPTH = MIPS_NREGS
);
    localparam int AW = $clog2(DEPTH);

    logic [AW-1:0]    ra;
    logic [AW-1:0]    rb;
    logic [WIDTH-1:0] qa;
    logic [WIDTH-1:0] qb;
    logic             we;
    logic [AW-1:0]    wa;
    logic [WIDTH-1:0] wd;

    modport master (output ra, rb, we, wa, wd, input qa, qb);
    modport slave  (input ra, rb, we, wa, wd, output qa, qb);
endinterface

// File: rtl/register_file_2r1w_mux_nx1.sv
// Parametrised N-to-1 word selector; one instance per register-file read port.
module mux_nx1 #(
    parameter int WIDTH = 32,
    parameter int N     = 32
) (
    input  logic [N-1:0][WIDTH-1:0] d,
    input  logic [$clog2(N)-1:0]    sel,
    output logic [WIDTH-1:0]        q
);
    assign q = d[sel];
endmodule

// File: rtl/register_file_2r1w.sv
// MIPS GPR file: DEPTH x WIDTH, two combinational reads, one synchronous write.
// Optional same-cycle write-to-read forwarding when REG_FILE_BYPASS_EN is defined.
module register_file_2r1w
    import mips_pkg::*;
#(
    parameter int WIDTH    = MIPS_XLEN,
    parameter int DEPTH    = MIPS_NREGS,
    parameter bit ZERO_REG = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset,
    register_file_2r1w_if.slave  bus
);
    localparam int          AW     = $clog2(DEPTH);
    localparam logic [AW-1:0] ZERO_A = AW'(ZERO_IDX);

    logic [DEPTH-1:0][WIDTH-1:0] regs;
    logic [WIDTH-1:0]            qa_raw;
    logic [WIDTH-1:0]            qb_raw;
    logic [WIDTH-1:0]            qa;
    logic [WIDTH-1:0]            qb;
    logic                        wr_ok;

    // Writes to the hardwired zero register are dropped at the source.
    assign wr_ok = bus.we && !(ZERO_REG && bus.wa == ZERO_A);

    always_ff @(posedge clk) begin
        if (reset)
            regs <= '0;
        else if (wr_ok)
            regs[bus.wa] <= bus.wd;
    end

    mux_nx1 #(.WIDTH(WIDTH), .N(DEPTH)) u_mux_a (.d(regs), .sel(bus.ra), .q(qa_raw));
    mux_nx1 #(.WIDTH(WIDTH), .N(DEPTH)) u_mux_b (.d(regs), .sel(bus.rb), .q(qb_raw));

    // Zero-forcing is applied last so it also overrides any forwarded data.
    always_comb begin
        qa = qa_raw;
        qb = qb_raw;
`ifdef REG_FILE_BYPASS_EN
        if (bus.we && !reset && bus.wa == bus.ra) qa = bus.wd;
        if (bus.we && !reset && bus.wa == bus.rb) qb = bus.wd;
`endif
        if (ZERO_REG && bus.ra == ZERO_A) qa = '0;
        if (ZERO_REG && bus.rb == ZERO_A) qb = '0;
    end

    assign bus.qa = qa;
    assign bus.qb = qb;
endmodule

// File: tb/tb_register_file_2r1w.sv
// Bench for register_file_2r1w: three configurations driven in lockstep
// (32x32 zero-reg, 32x32 plain r0, 8x4 zero-reg) against an array model.
module tb_register_file_2r1w;
    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  ra, rb, wa;
    logic        we;
    logic [31:0] wd;

    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    register_file_2r1w_if #(.WIDTH(32), .DEPTH(32)) b0 ();
    register_file_2r1w_if #(.WIDTH(32), .DEPTH(32)) b1 ();
    register_file_2r1w_if #(.WIDTH(8),  .DEPTH(4))  b2 ();

    assign b0.ra = ra;       assign b1.ra = ra;       assign b2.ra = ra[1:0];
    assign b0.rb = rb;       assign b1.rb = rb;       assign b2.rb = rb[1:0];
    assign b0.wa = wa;       assign b1.wa = wa;       assign b2.wa = wa[1:0];
    assign b0.we = we;       assign b1.we = we;       assign b2.we = we;
    assign b0.wd = wd;       assign b1.wd = wd;       assign b2.wd = wd[7:0];

    register_file_2r1w #(.WIDTH(32), .DEPTH(32), .ZERO_REG(1)) d0 (.clk(clk), .reset(rst), .bus(b0.slave));
    register_file_2r1w #(.WIDTH(32), .DEPTH(32), .ZERO_REG(0)) d1 (.clk(clk), .reset(rst), .bus(b1.slave));
    register_file_2r1w #(.WIDTH(8),  .DEPTH(4),  .ZERO_REG(1)) d2 (.clk(clk), .reset(rst), .bus(b2.slave));

    // Reference model: one word array per configuration, plus its shape.
    logic [31:0] m [3][32];
    bit          zr    [3] = '{1'b1, 1'b0, 1'b1};
    logic [4:0]  amask [3] = '{5'd31, 5'd31, 5'd3};
    logic [31:0] dmask [3] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_00FF};

    function automatic logic [31:0] exp_q(int k, logic [4:0] a);
        logic [4:0] aa;
        aa = a & amask[k];
        if (zr[k] && aa == 5'd0) return 32'h0;
`ifdef REG_FILE_BYPASS_EN
        if (we && !rst && (wa & amask[k]) == aa) return wd & dmask[k];
`endif
        return m[k][aa];
    endfunction

    function automatic logic [31:0] act(int k, bit p);
        case (k)
            0:       return p ? b0.qb : b0.qa;
            1:       return p ? b1.qb : b1.qa;
            default: return p ? {24'h0, b2.qb} : {24'h0, b2.qa};
        endcase
    endfunction

    // Advance one edge and apply the architectural write/reset rules to the model.
    task automatic tick();
        @(posedge clk);
        for (int k = 0; k < 3; k++) begin
            if (rst)
                for (int i = 0; i < 32; i++) m[k][i] = 32'h0;
            else if (we && !(zr[k] && (wa & amask[k]) == 5'd0))
                m[k][wa & amask[k]] = wd & dmask[k];
        end
        #2;
    endtask

    task automatic test_reset();
        rst = 1'b1; we = 1'b0; wa = '0; wd = '0; ra = '0; rb = '0;
        tick();
        rst = 1'b0; we = 1'b1; wa = 5'd5; wd = 32'hDEAD_BEEF;
        tick();
        we = 1'b0; ra = 5'd5; rb = 5'd5; #1;
        vectors++;
        if (b0.qa !== 32'hDEAD_BEEF) begin
            errors++; $display("FAIL reset_prewrite got %h exp %h", b0.qa, 32'hDEAD_BEEF);
        end
        rst = 1'b1; tick(); rst = 1'b0;
        for (int a = 0; a < 32; a++) begin
            ra = 5'(a); rb = 5'(31 - a); #1;
            for (int k = 0; k < 3; k++)
                for (int p = 0; p < 2; p++) begin
                    vectors++;
                    if (act(k, p[0]) !== 32'h0 || exp_q(k, p[0] ? rb : ra) !== 32'h0) begin
                        errors++;
                        $display("FAIL reset_clear cfg%0d port%0d addr%0d got %h exp %h", k, p, a, act(k, p[0]), 32'h0);
                    end
                end
        end
    endtask

    task automatic test_write_read();
        we = 1'b1; wa = 5'd7; wd = 32'h1234_5678; ra = 5'd7; rb = 5'd7; #1;
        for (int k = 0; k < 3; k++)
            for (int p = 0; p < 2; p++) begin
                vectors++;
                if (act(k, p[0]) !== exp_q(k, 5'd7)) begin
                    errors++; $display("FAIL write_pre_edge cfg%0d port%0d got %h exp %h", k, p, act(k, p[0]), exp_q(k, 5'd7));
                end
            end
        tick();
        we = 1'b0; #1;
        vectors++;
        if (b0.qa !== 32'h1234_5678 || b0.qb !== 32'h1234_5678 || b2.qa !== 8'h78) begin
            errors++; $display("FAIL write_post_edge got %h/%h/%h exp 12345678/12345678/78", b0.qa, b0.qb, b2.qa);
        end
    endtask

    task automatic test_zero_reg();
        we = 1'b1; wa = 5'd0; wd = 32'hFFFF_FFFF; ra = 5'd0; rb = 5'd0; #1;
        for (int k = 0; k < 3; k++) begin
            vectors++;
            if (act(k, 1'b0) !== exp_q(k, 5'd0)) begin
                errors++; $display("FAIL zero_pre_edge cfg%0d got %h exp %h", k, act(k, 1'b0), exp_q(k, 5'd0));
            end
        end
        tick();
        we = 1'b0; #1;
        vectors++;
        if (b0.qa !== 32'h0 || b1.qa !== 32'hFFFF_FFFF || b2.qb !== 8'h00) begin
            errors++; $display("FAIL zero_reg got %h/%h/%h exp 00000000/ffffffff/00", b0.qa, b1.qa, b2.qb);
        end
    endtask

    task automatic test_reset_collision();
        rst = 1'b1; we = 1'b1; wa = 5'd3; wd = 32'hAAAA_5555; ra = 5'd3; rb = 5'd3; #1;
        vectors++;
        if (b0.qa !== exp_q(0, 5'd3)) begin
            errors++; $display("FAIL collision_no_bypass got %h exp %h", b0.qa, exp_q(0, 5'd3));
        end
        tick();
        wd = 32'h5555_AAAA; tick();
        rst = 1'b0; we = 1'b0; #1;
        for (int k = 0; k < 3; k++) begin
            vectors++;
            if (act(k, 1'b0) !== 32'h0) begin
                errors++; $display("FAIL collision_r3 cfg%0d got %h exp %h", k, act(k, 1'b0), 32'h0);
            end
        end
        we = 1'b1; wd = 32'h0000_0C3C; tick(); we = 1'b0; #1;
        vectors++;
        if (b0.qb !== 32'h0000_0C3C) begin
            errors++; $display("FAIL first_write_after_reset got %h exp %h", b0.qb, 32'h0000_0C3C);
        end
    endtask

    task automatic test_dual_port();
        we = 1'b1; wa = 5'd1;  wd = 32'h1111_1111; tick();
        wa = 5'd31; wd = 32'h3131_3131; tick();
        we = 1'b0; ra = 5'd1; rb = 5'd31; #1;
        vectors++;
        if (b0.qa !== 32'h1111_1111 || b0.qb !== 32'h3131_3131) begin
            errors++; $display("FAIL dual_port got %h/%h exp 11111111/31313131", b0.qa, b0.qb);
        end
        ra = 5'd31; rb = 5'd1; #1;
        vectors++;
        if (b1.qa !== 32'h3131_3131 || b1.qb !== 32'h1111_1111 || b2.qa !== 8'h31 || b2.qb !== 8'h11) begin
            errors++; $display("FAIL dual_port_swap got %h/%h/%h/%h exp 31313131/11111111/31/11", b1.qa, b1.qb, b2.qa, b2.qb);
        end
    endtask

    task automatic test_param_sweep();
        we = 1'b1; wa = 5'd3; wd = 32'h0000_00A5; tick();
        we = 1'b0; ra = 5'd3; rb = 5'd2; #1;
        vectors++;
        if (b2.qa !== 8'hA5 || b2.qb !== 8'h00) begin
            errors++; $display("FAIL sweep_8x4 got %h/%h exp a5/00", b2.qa, b2.qb);
        end
        rb = 5'd3; #1;
        vectors++;
        if (b2.qb !== 8'hA5) begin
            errors++; $display("FAIL sweep_8x4_portb got %h exp a5", b2.qb);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            rst = ($urandom_range(0, 24) == 0);
            we  = ($urandom_range(0, 3) != 0);
            wa  = 5'($urandom);
            wd  = $urandom;
            ra  = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom);
            rb  = ($urandom_range(0, 3) == 0) ? ra : 5'($urandom);
            #1;
            for (int k = 0; k < 3; k++)
                for (int p = 0; p < 2; p++) begin
                    vectors++;
                    if (act(k, p[0]) !== exp_q(k, p[0] ? rb : ra)) begin
                        errors++;
                        $display("FAIL random n%0d cfg%0d port%0d got %h exp %h", n, k, p, act(k, p[0]), exp_q(k, p[0] ? rb : ra));
                    end
                end
            tick();
        end
        rst = 1'b0; we = 1'b0;
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_zero_reg();
        test_reset_collision();
        test_dual_port();
        test_param_sweep();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
